led_pattern_gen: RTL and testbench

LED_PATTERN_GEN -- requirements
Module: led_pattern_gen

---
 rtl/led_pattern_gen.sv | 121 ++++++++++++
 tb/tb_led_pattern_gen.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/led_pattern_gen.sv
// LED pattern generator: rotate-left, rotate-right, ping-pong and fill/drain patterns
// advanced by a programmable tick divider on a single clock domain.
module led_pattern_gen #(
    parameter int unsigned N_LED    = 8,
    parameter int unsigned TICK_DIV = 1_000_000
) (
    input  logic             clk1MHz,
    input  logic             rst,
    input  logic [1:0]       mode,
    input  logic [1:0]       speed,
    input  logic             pause,
    output logic [N_LED-1:0] led,
    output logic             step
);

    localparam int unsigned CntW = $clog2(TICK_DIV);
    localparam logic [N_LED-1:0] LedOne = {{(N_LED-1){1'b0}}, 1'b1};

    typedef enum logic {StUp, StDown} pp_state_e;
    typedef enum logic {PhFill, PhDrain} fd_phase_e;

    logic [1:0]       mode_q, mode_d;
    logic [N_LED-1:0] led_q, led_d;
    logic             step_q, step_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    pp_state_e        pp_q, pp_d;
    fd_phase_e        fd_q, fd_d;

    logic [31:0]      limit;
    logic             tick_hit;
    logic [N_LED-1:0] init_pat;
    logic [N_LED-1:0] rot_l, rot_r, fill_v, drain_v;

    // ">=" so that raising speed past the current count fires a tick instead of wrapping.
    assign limit    = TICK_DIV >> speed;
    assign tick_hit = (32'(cnt_q) >= (limit - 32'd1));

    assign init_pat = (mode == 2'b11) ? '0 : LedOne;

    assign rot_l   = {led_q[N_LED-2:0], led_q[N_LED-1]};
    assign rot_r   = {led_q[0], led_q[N_LED-1:1]};
    assign fill_v  = {led_q[N_LED-2:0], 1'b1};
    assign drain_v = led_q >> 1;

    always_comb begin
        mode_d = mode_q;
        led_d  = led_q;
        step_d = 1'b0;
        cnt_d  = cnt_q;
        pp_d   = pp_q;
        fd_d   = fd_q;

        if (mode != mode_q) begin
            mode_d = mode;
            led_d  = init_pat;
            cnt_d  = '0;
            pp_d   = StUp;
            fd_d   = PhFill;
        end else if (!pause) begin
            if (tick_hit) begin
                cnt_d  = '0;
                step_d = 1'b1;
                case (mode_q)
                    2'b00: led_d = rot_l;
                    2'b01: led_d = rot_r;
                    2'b10: begin
                        if (pp_q == StUp) begin
                            if (led_q[N_LED-1]) begin
                                pp_d  = StDown;
                                led_d = led_q >> 1;
                            end else begin
                                led_d = led_q << 1;
                            end
                        end else begin
                            if (led_q[0]) begin
                                pp_d  = StUp;
                                led_d = led_q << 1;
                            end else begin
                                led_d = led_q >> 1;
                            end
                        end
                    end
                    2'b11: begin
                        if (fd_q == PhFill) begin
                            led_d = fill_v;
                            if (&fill_v) fd_d = PhDrain;
                        end else begin
                            led_d = drain_v;
                            if (drain_v == '0) fd_d = PhFill;
                        end
                    end
                    default: led_d = led_q;
                endcase
            end else begin
                cnt_d = cnt_q + CntW'(1);
            end
        end
    end

    always_ff @(posedge clk1MHz) begin
        if (rst) begin
            mode_q <= mode;
            led_q  <= init_pat;
            step_q <= 1'b0;
            cnt_q  <= '0;
            pp_q   <= StUp;
            fd_q   <= PhFill;
        end else begin
            mode_q <= mode_d;
            led_q  <= led_d;
            step_q <= step_d;
            cnt_q  <= cnt_d;
            pp_q   <= pp_d;
            fd_q   <= fd_d;
        end
    end

    assign led  = led_q;
    assign step = step_q;

endmodule

// File: tb/tb_led_pattern_gen.sv
// Directed bench for led_pattern_gen with N_LED=8, TICK_DIV=8.
module tb_led_pattern_gen;

    logic       clk1MHz = 1'b0;
    logic       rst;
    logic [1:0] mode;
    logic [1:0] speed;
    logic       pause;
    logic [7:0] led;
    logic       step;

    int total = 0;
    int bad   = 0;

    logic [7:0] pp_exp [15] = '{8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h40,
                                8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01, 8'h02};
    logic [7:0] fd_exp [17] = '{8'h01, 8'h03, 8'h07, 8'h0F, 8'h1F, 8'h3F, 8'h7F, 8'hFF,
                                8'h7F, 8'h3F, 8'h1F, 8'h0F, 8'h07, 8'h03, 8'h01, 8'h00,
                                8'h01};

    always #5 clk1MHz = ~clk1MHz;

    led_pattern_gen #(
        .N_LED    (8),
        .TICK_DIV (8)
    ) dut (
        .clk1MHz (clk1MHz),
        .rst     (rst),
        .mode    (mode),
        .speed   (speed),
        .pause   (pause),
        .led     (led),
        .step    (step)
    );

    task automatic cyc(input int n);
        repeat (n) @(posedge clk1MHz);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst   = 1'b1;
        mode  = 2'b00;
        speed = 2'b00;
        pause = 1'b0;
        cyc(1);
        chk("rst_led", 32'(led), 32'h01);
        chk("rst_step", 32'(step), 32'h0);
        chk("rst_cnt", 32'(dut.cnt_q), 32'h0);
        rst = 1'b0;

        // Rotate-left: one step every 8 cycles, wrapping back to 01 at cycle 64.
        for (int c = 1; c <= 64; c++) begin
            cyc(1);
            chk("rotl_led", 32'(led), 32'h1 << ((c / 8) % 8));
            chk("rotl_step", 32'(step), ((c % 8) == 0) ? 32'h1 : 32'h0);
        end

        // Ping-pong.
        mode = 2'b10;
        cyc(1);
        chk("pp_chg_led", 32'(led), 32'h01);
        chk("pp_chg_step", 32'(step), 32'h0);
        chk("pp_chg_cnt", 32'(dut.cnt_q), 32'h0);
        for (int i = 0; i < 15; i++) begin
            cyc(7);
            chk("pp_gap_step", 32'(step), 32'h0);
            cyc(1);
            chk("pp_led", 32'(led), 32'(pp_exp[i]));
            chk("pp_step", 32'(step), 32'h1);
        end
        cyc(56);
        chk("pp_down_led", 32'(led), 32'h40);
        cyc(3);
        rst = 1'b1;
        cyc(1);
        rst = 1'b0;
        chk("pp_rst_led", 32'(led), 32'h01);
        chk("pp_rst_cnt", 32'(dut.cnt_q), 32'h0);
        chk("pp_rst_step", 32'(step), 32'h0);
        cyc(7);
        chk("pp_rst_hold_led", 32'(led), 32'h01);
        chk("pp_rst_hold_step", 32'(step), 32'h0);
        cyc(1);
        chk("pp_rst_up_led", 32'(led), 32'h02);
        chk("pp_rst_up_step", 32'(step), 32'h1);

        // Rotate-right with speed raised past the current count.
        mode = 2'b01;
        cyc(1);
        chk("rr_chg_led", 32'(led), 32'h01);
        chk("rr_chg_cnt", 32'(dut.cnt_q), 32'h0);
        cyc(5);
        chk("rr_cnt5", 32'(dut.cnt_q), 32'h5);
        chk("rr_cnt5_led", 32'(led), 32'h01);
        speed = 2'b11;
        cyc(1);
        chk("spd_led", 32'(led), 32'h80);
        chk("spd_step", 32'(step), 32'h1);
        chk("spd_cnt", 32'(dut.cnt_q), 32'h0);
        cyc(1);
        chk("spd_led2", 32'(led), 32'h40);
        chk("spd_step2", 32'(step), 32'h1);
        cyc(1);
        chk("spd_led3", 32'(led), 32'h20);
        chk("spd_step3", 32'(step), 32'h1);
        speed = 2'b00;

        // Pause with cnt=3.
        cyc(3);
        chk("pre_pause_cnt", 32'(dut.cnt_q), 32'h3);
        chk("pre_pause_step", 32'(step), 32'h0);
        pause = 1'b1;
        for (int i = 0; i < 20; i++) begin
            cyc(1);
            chk("pause_led", 32'(led), 32'h20);
            chk("pause_cnt", 32'(dut.cnt_q), 32'h3);
            chk("pause_step", 32'(step), 32'h0);
        end
        pause = 1'b0;
        cyc(4);
        chk("unpause_step", 32'(step), 32'h0);
        chk("unpause_cnt", 32'(dut.cnt_q), 32'h7);
        chk("unpause_led", 32'(led), 32'h20);
        cyc(1);
        chk("unpause_tick_led", 32'(led), 32'h10);
        chk("unpause_tick_step", 32'(step), 32'h1);

        // Mode 00 up to led=10, then switch to fill/drain mid-step.
        mode = 2'b00;
        cyc(1);
        chk("m0_led", 32'(led), 32'h01);
        cyc(32);
        chk("m0_led10", 32'(led), 32'h10);
        chk("m0_step", 32'(step), 32'h1);
        cyc(2);
        mode = 2'b11;
        cyc(1);
        chk("m3_chg_led", 32'(led), 32'h00);
        chk("m3_chg_cnt", 32'(dut.cnt_q), 32'h0);
        chk("m3_chg_step", 32'(step), 32'h0);
        for (int i = 0; i < 17; i++) begin
            cyc(8);
            chk("fd_led", 32'(led), 32'(fd_exp[i]));
            chk("fd_step", 32'(step), 32'h1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
